abc_sweep_checker: RTL



---
 rtl/abc_sweep_pkg.sv | 20 ++
 rtl/abc_sweep_checker_dwell_counter.sv | 28 ++
 rtl/abc_sweep_checker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/abc_sweep_pkg.sv
// Shared definitions for the A/B/C sweep checker: FSM encoding and vector limits.
package abc_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  localparam logic [2:0] VEC_LAST    = 3'd7;
  localparam int         NUM_VECTORS = 8;
  localparam int         DWELL_W     = 8;

  // Terminal dwell count for a given settle time (settle time is 1..255).
  function automatic logic [DWELL_W-1:0] dwell_last(input int dwell_cycles);
    return DWELL_W'(dwell_cycles - 1);
  endfunction

endpackage

// File: rtl/abc_sweep_checker_dwell_counter.sv
// Loadable up-counter that flags when it reaches a fixed terminal value.
module dwell_counter #(
  parameter int          W    = 8,
  parameter logic [W-1:0] LAST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/abc_sweep_checker.sv
// Steps {A,B,C} through all eight vectors, compares the two implementation
// outputs at the end of each settle window and reports the sweep result.
module abc_sweep_checker
  import abc_sweep_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int ERR_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             F_0,
  input  logic             F_1,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             match,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_err_vec,
  output sweep_state_e     state_dbg
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = dwell_last(DWELL_CYCLES);

  sweep_state_e     state;
  logic [2:0]       vec;
  logic             dwell_load;
  logic             dwell_en;
  logic             dwell_tc;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Handshake: start is a one-cycle request, honoured only in IDLE or DONE;
  // a pulse while busy is dropped without any side effect.
  always_comb begin
    dwell_load = 1'b0;
    dwell_en   = 1'b0;
    case (state)
      IDLE, DONE: dwell_load = start;
      SETTLE:     dwell_en   = 1'b1;
      SAMPLE:     dwell_load = 1'b1;
      default:    dwell_load = 1'b0;
    endcase
  end

  dwell_counter #(
    .W    (DWELL_W),
    .LAST (DWELL_LAST)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .load_val ('0),
    .en       (dwell_en),
    .tc       (dwell_tc)
  );

  // Saturating count; only SAMPLE may advance it.
  always_comb begin
    mismatch = F_0 ^ F_1;
    err_next = err_cnt;
    if (state == SAMPLE && mismatch && !(&err_cnt)) begin
      err_next = err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      vec           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      match         <= 1'b0;
      err_cnt       <= '0;
      first_err_vec <= '0;
    end else begin
      match <= (F_0 == F_1);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= SETTLE;
            vec           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vec <= '0;
          end
        end
        SETTLE: begin
          if (dwell_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_cnt <= err_next;
          if (mismatch && err_cnt == '0) begin
            first_err_vec <= vec;
          end
          if (vec == VEC_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= SETTLE;
            vec   <= vec + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stimulus comes straight off the vector register so it cannot glitch.
  assign {A, B, C} = vec;
  assign state_dbg = state;

endmodule
